// File: rtl/mmio_store_sink.sv
// rtl/mmio_store_sink.sv - store-capture register window with a FIFO drained over a valid/ready port
module mmio_store_sink #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0100,  // low 4 bits must be zero
  parameter int          DEPTH     = 8               // power of 2, at least 2
) (
  input  logic        clk,
  input  logic        reset,       // asynchronous, active-low
  input  logic [31:0] Adr,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  output logic        Sel,
  output logic [31:0] ReadData,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic        done,
  output logic [31:0] done_code,
  output logic        overflow
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] OFF_DATA   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_DONE   = 2'd2;
  localparam logic [1:0] OFF_STORES = 2'd3;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [31:0]   stores;

  logic [1:0] off;
  logic       empty;
  logic       full;
  logic       pop;
  logic       wr_hit;
  logic       push_req;
  logic       push_ok;
  logic       push_drop;
  logic       ovf_clear;
  logic       done_wr;

  // Byte-lane bits are irrelevant: the window is word-addressed.
  logic unused_adr_bits;
  assign unused_adr_bits = ^Adr[1:0];

  // Address decode and FIFO handshake terms.
  always_comb begin
    Sel       = (Adr[31:4] == BASE_ADDR[31:4]);
    off       = Adr[3:2];
    empty     = (count == '0);
    full      = (count == (AW+1)'(DEPTH));
    pop       = !empty && out_ready;
    wr_hit    = MemWrite && Sel;
    push_req  = wr_hit && (off == OFF_DATA);
    // A full FIFO still accepts when the head leaves on the same edge.
    push_ok   = push_req && (!full || pop);
    push_drop = push_req && !push_ok;
    ovf_clear = wr_hit && (off == OFF_STATUS) && WriteData[0];
    done_wr   = wr_hit && (off == OFF_DONE);
  end

  assign out_valid = !empty;
  assign out_data  = mem[rd_ptr];

  // Read mux is side-effect free and reflects current state only.
  always_comb begin
    ReadData = 32'h0;
    if (Sel) begin
      case (off)
        OFF_DATA:   ReadData = {{(31-AW){1'b0}}, count};
        OFF_STATUS: ReadData = {29'b0, overflow, full, empty};
        OFF_DONE:   ReadData = done_code;
        OFF_STORES: ReadData = stores;
        default:    ReadData = 32'h0;
      endcase
    end
  end

  // FIFO storage is deliberately not reset; count alone defines validity.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= WriteData;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Accepted-push counter, wraps at 2^32.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stores <= 32'h0;
    end else if (push_ok) begin
      stores <= stores + 32'h1;
    end
  end

  // Sticky overflow; set and clear can never coincide since they use different offsets.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (push_drop) begin
      overflow <= 1'b1;
    end else if (ovf_clear) begin
      overflow <= 1'b0;
    end
  end

  // Sticky done flag; later DONE writes only refresh the code.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done      <= 1'b0;
      done_code <= 32'h0;
    end else if (done_wr) begin
      done      <= 1'b1;
      done_code <= WriteData;
    end
  end

endmodule

// File: tb/tb_mmio_store_sink.sv
// tb/tb_mmio_store_sink.sv - table, directed and randomized model checks for mmio_store_sink
module tb_mmio_store_sink;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Adr;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        Sel;
  logic [31:0] ReadData;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic        done;
  logic [31:0] done_code;
  logic        overflow;

  int tests  = 0;
  int failed = 0;

  mmio_store_sink #(.BASE_ADDR(32'h0000_0100), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .Adr(Adr), .WriteData(WriteData), .MemWrite(MemWrite),
    .Sel(Sel), .ReadData(ReadData), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .done(done), .done_code(done_code), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] wd;
    bit          we;
    bit          rdy;
    logic [31:0] rd_adr;
    logic [31:0] exp_rd;
    bit          exp_valid;
    bit          chk_data;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle with the given bus inputs; returns 1 ns after the edge with strobes idle.
  task automatic cyc(input logic [31:0] a, input logic [31:0] d, input bit we, input bit rdy);
    @(negedge clk);
    Adr = a; WriteData = d; MemWrite = we; out_ready = rdy;
    @(posedge clk);
    #1;
    MemWrite = 1'b0; out_ready = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    Adr = a;
    #1;
    chk(name, ReadData, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  // Reference model state for the randomized phase.
  int unsigned q[$];
  bit          m_ovf;
  bit          m_done;
  logic [31:0] m_code;
  logic [31:0] m_stores;

  initial begin
    reset = 1'b0; Adr = 32'h0; WriteData = 32'h0; MemWrite = 1'b0; out_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rst_sel", {31'b0, Sel}, 32'h0);
    chk("rst_rdata", ReadData, 32'h0);
    chk("rst_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    chk("rst_code", done_code, 32'h0);
    chk("rst_ovf", {31'b0, overflow}, 32'h0);
    Adr = 32'h104;
    #1;
    chk("rst_sel_104", {31'b0, Sel}, 32'h1);
    chk("rst_status", ReadData, 32'h1);

    // adr, wd, we, rdy, rd_adr, exp_rd, exp_valid, chk_data, exp_data
    vecs[0] = '{32'h100, 32'hA5A5_0001, 1'b1, 1'b0, 32'h100, 32'h1, 1'b1, 1'b1, 32'hA5A5_0001};
    vecs[1] = '{32'h000, 32'h0,         1'b0, 1'b0, 32'h10C, 32'h1, 1'b1, 1'b1, 32'hA5A5_0001};
    vecs[2] = '{32'h000, 32'h0,         1'b0, 1'b1, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0};
    vecs[3] = '{32'h108, 32'hCAFE_0000, 1'b1, 1'b0, 32'h108, 32'hCAFE_0000, 1'b0, 1'b0, 32'h0};
    vecs[4] = '{32'h10B, 32'h0000_0001, 1'b1, 1'b0, 32'h108, 32'h1, 1'b0, 1'b0, 32'h0};
    vecs[5] = '{32'h200, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h108, 32'h1, 1'b0, 1'b0, 32'h0};
    vecs[6] = '{32'h200, 32'h0,         1'b1, 1'b0, 32'h10C, 32'h1, 1'b0, 1'b0, 32'h0};
    vecs[7] = '{32'h000, 32'h0,         1'b0, 1'b0, 32'h200, 32'h0, 1'b0, 1'b0, 32'h0};
    vecs[8] = '{32'h10E, 32'h1234_5678, 1'b1, 1'b0, 32'h104, 32'h1, 1'b0, 1'b0, 32'h0};
    for (int i = 0; i < 9; i++) begin
      cyc(vecs[i].adr, vecs[i].wd, vecs[i].we, vecs[i].rdy);
      Adr = vecs[i].rd_adr;
      #1;
      chk($sformatf("vec%0d_rd", i), ReadData, vecs[i].exp_rd);
      chk($sformatf("vec%0d_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].exp_valid});
      if (vecs[i].chk_data) chk($sformatf("vec%0d_data", i), out_data, vecs[i].exp_data);
    end
    chk("tbl_done", {31'b0, done}, 32'h1);
    chk("tbl_code", done_code, 32'h1);

    // Asynchronous reset between edges with words queued.
    for (int i = 0; i < 3; i++) cyc(32'h100, 32'h70 + i, 1'b1, 1'b0);
    chk("pre_rst_valid", {31'b0, out_valid}, 32'h1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_valid", {31'b0, out_valid}, 32'h0);
    chk("async_done", {31'b0, done}, 32'h0);
    #1 reset = 1'b1;
    rd_chk("async_count", 32'h100, 32'h0);
    rd_chk("async_stores", 32'h10C, 32'h0);

    // Overflow: nine stores into an eight-deep FIFO, then drain.
    for (int i = 1; i <= 9; i++) cyc(32'h100, i, 1'b1, 1'b0);
    rd_chk("ovf_status", 32'h104, 32'h6);
    rd_chk("ovf_stores", 32'h10C, 32'h8);
    chk("ovf_flag", {31'b0, overflow}, 32'h1);
    for (int i = 1; i <= 8; i++) begin
      #1;
      chk($sformatf("drain%0d_valid", i), {31'b0, out_valid}, 32'h1);
      chk($sformatf("drain%0d_data", i), out_data, i);
      cyc(32'h0, 32'h0, 1'b0, 1'b1);
    end
    chk("drain_empty", {31'b0, out_valid}, 32'h0);
    cyc(32'h104, 32'hFFFF_FFFE, 1'b1, 1'b0);
    chk("clr_bit0_zero", {31'b0, overflow}, 32'h1);
    cyc(32'h104, 32'h1, 1'b1, 1'b0);
    rd_chk("clr_status", 32'h104, 32'h1);

    // Full FIFO with a push and pop on the same edge.
    for (int i = 0; i < 8; i++) cyc(32'h100, 32'h10 + i, 1'b1, 1'b0);
    rd_chk("full_status", 32'h104, 32'h2);
    cyc(32'h100, 32'h55, 1'b1, 1'b1);
    rd_chk("pp_count", 32'h100, 32'h8);
    chk("pp_ovf", {31'b0, overflow}, 32'h0);
    rd_chk("pp_stores", 32'h10C, 32'h11);
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("pp%0d_data", i), out_data, (i == 7) ? 32'h55 : 32'h11 + i);
      cyc(32'h0, 32'h0, 1'b0, 1'b1);
    end
    chk("pp_empty", {31'b0, out_valid}, 32'h0);

    // Randomized traffic against a queue-based model.
    do_reset();
    q.delete(); m_ovf = 0; m_done = 0; m_code = 0; m_stores = 0;
    for (int n = 0; n < 600; n++) begin
      logic [31:0] a, d, exp_rd;
      bit we, rdy, sel, pop, push_req, push_ok;
      int sel_kind;
      sel_kind = $urandom_range(0, 9);
      if (sel_kind < 6)      a = 32'h100 + 32'($urandom_range(0, 15)) + ((sel_kind < 3) ? 32'h0 : 32'h0);
      else if (sel_kind < 8) a = 32'h100 + 32'(4 * $urandom_range(0, 3));
      else if (sel_kind == 8) a = 32'h200;
      else                   a = $urandom;
      if (sel_kind < 3) a = 32'h100 + 32'($urandom_range(0, 3));
      d   = $urandom;
      we  = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) == 0);
      @(negedge clk);
      Adr = a; WriteData = d; MemWrite = we; out_ready = rdy;
      #1;
      sel = (a >= 32'h100) && (a < 32'h110);
      exp_rd = 32'h0;
      if (sel) begin
        case ((a - 32'h100) / 4)
          0: exp_rd = q.size();
          1: exp_rd = (m_ovf ? 4 : 0) + ((q.size() == DEPTH) ? 2 : 0) + ((q.size() == 0) ? 1 : 0);
          2: exp_rd = m_code;
          default: exp_rd = m_stores;
        endcase
      end
      chk("rnd_sel", {31'b0, Sel}, {31'b0, sel});
      chk("rnd_rd", ReadData, exp_rd);
      chk("rnd_valid", {31'b0, out_valid}, (q.size() != 0) ? 32'h1 : 32'h0);
      if (q.size() != 0) chk("rnd_data", out_data, q[0]);
      chk("rnd_ovf", {31'b0, overflow}, {31'b0, m_ovf});
      chk("rnd_done", {31'b0, done}, {31'b0, m_done});
      chk("rnd_code", done_code, m_code);
      pop      = (q.size() != 0) && rdy;
      push_req = sel && we && (a < 32'h104);
      push_ok  = push_req && ((q.size() < DEPTH) || pop);
      if (pop) void'(q.pop_front());
      if (push_ok) begin
        q.push_back(d);
        m_stores = m_stores + 1;
      end
      if (push_req && !push_ok) m_ovf = 1;
      if (sel && we && (a >= 32'h104) && (a < 32'h108) && d[0]) m_ovf = 0;
      if (sel && we && (a >= 32'h108) && (a < 32'h10C)) begin
        m_done = 1;
        m_code = d;
      end
    end
    @(negedge clk);
    MemWrite = 1'b0; out_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
